// File: rtl/rs_seq_if.sv
// rs_seq_if: handshake bundle between the RS decode sequencer and its stages/host.
// Carries the timeout flag only when RS_SEQ_WATCHDOG_EN is defined.
interface rs_seq_if #(
    parameter int W = 5
);
    logic start, busy, done, fail;
    logic [W-1:0] err_count;
    logic syn_start, syn_done, syn_all_zero;
    logic bm_start, bm_done;
    logic [W-1:0] bm_degree;
    logic chien_start, chien_done;
    logic [W-1:0] chien_roots;
    logic forney_start, forney_done;
    logic [2:0] stage;
`ifdef RS_SEQ_WATCHDOG_EN
    logic timeout;
`endif
    modport master (
        input start, syn_done, syn_all_zero, bm_done, bm_degree, chien_done, chien_roots, forney_done,
        output busy, done, fail, err_count, syn_start, bm_start, chien_start, forney_start, stage
`ifdef RS_SEQ_WATCHDOG_EN
        , output timeout
`endif
    );
    modport slave (
        output start, syn_done, syn_all_zero, bm_done, bm_degree, chien_done, chien_roots, forney_done,
        input busy, done, fail, err_count, syn_start, bm_start, chien_start, forney_start, stage
`ifdef RS_SEQ_WATCHDOG_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/rs_decode_sequencer.sv
// rs_decode_sequencer: runs syndrome, BM, Chien and Forney stages in order and reports the result.
// Optional per-stage watchdog enabled by RS_SEQ_WATCHDOG_EN.
module rs_decode_sequencer #(
    parameter int MAX_ERRORS = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic clk,
    input logic rst,
    rs_seq_if.master bus
);
    localparam int W = $clog2(MAX_ERRORS) + 1;
    localparam logic [2:0] IDLE = 3'd0, SYN = 3'd1, BM = 3'd2, CHIEN = 3'd3, FORNEY = 3'd4, FIN = 3'd5;
    logic [2:0] state, nxt;
    logic start_ok, syn_ok, bm_ok, chien_ok, forney_ok, bad_deg, mismatch, fail_set, wd_fire;
    assign start_ok = state == IDLE && bus.start;
    // A done level is only trusted once the matching start pulse has retired.
    assign syn_ok = state == SYN && !bus.syn_start && bus.syn_done;
    assign bm_ok = state == BM && !bus.bm_start && bus.bm_done;
    assign chien_ok = state == CHIEN && !bus.chien_start && bus.chien_done;
    assign forney_ok = state == FORNEY && !bus.forney_start && bus.forney_done;
    assign bad_deg = bus.bm_degree == '0 || bus.bm_degree > W'(MAX_ERRORS);
    assign mismatch = bus.chien_roots != bus.err_count;
    assign fail_set = (bm_ok && bad_deg) || (chien_ok && mismatch) || wd_fire;
    assign bus.stage = state;
`ifdef RS_SEQ_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] wd_cnt;
    logic in_stage;
    assign in_stage = state inside {SYN, BM, CHIEN, FORNEY};
`endif
    always_comb begin
        nxt = state;
        wd_fire = 1'b0;
        case (state)
            IDLE:    nxt = bus.start ? SYN : IDLE;
            SYN:     nxt = syn_ok ? (bus.syn_all_zero ? FIN : BM) : SYN;
            BM:      nxt = bm_ok ? (bad_deg ? FIN : CHIEN) : BM;
            CHIEN:   nxt = chien_ok ? (mismatch ? FIN : FORNEY) : CHIEN;
            FORNEY:  nxt = forney_ok ? FIN : FORNEY;
            default: nxt = IDLE;
        endcase
`ifdef RS_SEQ_WATCHDOG_EN
        wd_fire = in_stage && nxt == state && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
        if (wd_fire) nxt = FIN;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.fail <= 1'b0;
            bus.err_count <= '0;
            bus.syn_start <= 1'b0;
            bus.bm_start <= 1'b0;
            bus.chien_start <= 1'b0;
            bus.forney_start <= 1'b0;
        end else begin
            state <= nxt;
            bus.syn_start <= start_ok;
            bus.bm_start <= state != BM && nxt == BM;
            bus.chien_start <= state != CHIEN && nxt == CHIEN;
            bus.forney_start <= state != FORNEY && nxt == FORNEY;
            bus.done <= state != FIN && nxt == FIN;
            bus.busy <= nxt != IDLE && nxt != FIN;
            bus.fail <= start_ok ? 1'b0 : bus.fail | fail_set;
            bus.err_count <= start_ok ? '0 : bm_ok ? bus.bm_degree : bus.err_count;
        end
    end
`ifdef RS_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            bus.timeout <= 1'b0;
        end else begin
            wd_cnt <= (in_stage && nxt == state) ? wd_cnt + 1'b1 : '0;
            bus.timeout <= start_ok ? 1'b0 : bus.timeout | wd_fire;
        end
    end
`endif
endmodule

// File: tb/tb_rs_decode_sequencer.sv
// tb_rs_decode_sequencer: randomized stage responders checked against a scenario-level outcome model.
module tb_rs_decode_sequencer;
    localparam int MAXE = 16;
    localparam int W = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    int n_pulse[4] = '{default: 0};
    always #5 clk = ~clk;
    rs_seq_if #(.W(W)) bus ();
    rs_decode_sequencer #(.MAX_ERRORS(MAXE), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );
    always @(negedge clk) begin
        if (bus.syn_start) n_pulse[0]++;
        if (bus.bm_start) n_pulse[1]++;
        if (bus.chien_start) n_pulse[2]++;
        if (bus.forney_start) n_pulse[3]++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic st(input int s);
        case (s)
            0: return bus.syn_start;
            1: return bus.bm_start;
            2: return bus.chien_start;
            default: return bus.forney_start;
        endcase
    endfunction
    task automatic set_done(input int s, input logic v);
        case (s)
            0: bus.syn_done = v;
            1: bus.bm_done = v;
            2: bus.chien_done = v;
            default: bus.forney_done = v;
        endcase
    endtask
    // Stage model: keeps a stale done through its start cycle, drops it, then finishes after a random delay.
    task automatic serve(input int s, input bit az, input logic [W-1:0] deg, input logic [W-1:0] roots);
        @(negedge clk);
        set_done(s, 1'b0);
        case (s)
            0: bus.syn_all_zero = 1'($urandom);
            1: bus.bm_degree = W'($urandom);
            2: bus.chien_roots = W'($urandom);
            default: ;
        endcase
        if (s == 1 && $urandom_range(0, 1) == 1) bus.chien_done = 1'b1;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
        end
        bus.start = 1'b0;
        case (s)
            0: bus.syn_all_zero = az;
            1: bus.bm_degree = deg;
            2: bus.chien_roots = roots;
            default: ;
        endcase
        set_done(s, 1'b1);
    endtask
    task automatic run_decode(input bit az, input logic [W-1:0] deg, input logic [W-1:0] roots, input bit abort);
        bit run[4];
        bit bad, efail;
        logic [W-1:0] ecnt;
        int base[4];
        int q[$];
        bad = deg == 0 || int'(deg) > MAXE;
        run[0] = 1'b1;
        run[1] = !az;
        run[2] = !az && !bad;
        run[3] = run[2] && roots == deg;
        efail = !az && (bad || roots != deg);
        ecnt = az ? '0 : deg;
        for (int s = 0; s < 4; s++) if (run[s]) q.push_back(s);
        base = n_pulse;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("syn_start_lat", bus.syn_start, 1);
        check("busy_on", bus.busy, 1);
        check("fail_clr", bus.fail, 0);
        check("cnt_clr", bus.err_count, 0);
`ifdef RS_SEQ_WATCHDOG_EN
        check("timeout_clr", bus.timeout, 0);
`endif
        for (int i = 0; i < q.size(); i++) begin
            if (abort && q[i] == 2) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_stage", bus.stage, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_chien_start", bus.chien_start, 0);
                bus.syn_done = 1'b0;
                bus.bm_done = 1'b0;
                bus.chien_done = 1'b0;
                bus.forney_done = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            serve(q[i], az, deg, roots);
            @(negedge clk);
            if (i + 1 < q.size()) begin
                check($sformatf("start%0d", q[i + 1]), st(q[i + 1]), 1);
                check("stage", bus.stage, q[i + 1] + 1);
            end else begin
                check("done", bus.done, 1);
                check("busy_fin", bus.busy, 0);
                check("fail", bus.fail, efail);
                check("err_count", bus.err_count, ecnt);
                check("stage_fin", bus.stage, 5);
            end
        end
        @(negedge clk);
        check("done_pulse", bus.done, 0);
        check("stage_idle", bus.stage, 0);
        for (int s = 0; s < 4; s++) check($sformatf("pulses%0d", s), n_pulse[s] - base[s], run[s]);
    endtask
`ifdef RS_SEQ_WATCHDOG_EN
    task automatic wd_test();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        serve(0, 1'b0, 3, 3);
        @(negedge clk);
        check("wd_bm_start", bus.bm_start, 1);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            bus.bm_done = 1'b0;
            seen |= bus.done;
        end
        check("wd_early_done", seen, 0);
        @(negedge clk);
        check("wd_done", bus.done, 1);
        check("wd_fail", bus.fail, 1);
        check("wd_timeout", bus.timeout, 1);
        @(negedge clk);
    endtask
`endif
    initial begin
        bus.start = 1'b0;
        bus.syn_done = 1'b0;
        bus.syn_all_zero = 1'b0;
        bus.bm_done = 1'b0;
        bus.bm_degree = '0;
        bus.chien_done = 1'b0;
        bus.chien_roots = '0;
        bus.forney_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy0", bus.busy, 0);
        check("rst_done0", bus.done, 0);
        check("rst_fail0", bus.fail, 0);
        check("rst_cnt0", bus.err_count, 0);
        check("rst_stage0", bus.stage, 0);
        check("rst_starts0", {bus.syn_start, bus.bm_start, bus.chien_start, bus.forney_start}, 0);
        rst = 1'b0;
        run_decode(1'b1, 0, 0, 1'b0);
        run_decode(1'b0, 3, 3, 1'b0);
        run_decode(1'b0, 17, 17, 1'b0);
        run_decode(1'b0, 5, 4, 1'b0);
        run_decode(1'b0, 16, 16, 1'b0);
        run_decode(1'b0, 0, 0, 1'b0);
        run_decode(1'b0, 3, 3, 1'b1);
        run_decode(1'b0, 2, 2, 1'b0);
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] d, r;
            d = W'($urandom_range(0, 20));
            r = ($urandom_range(0, 3) != 0) ? d : W'($urandom_range(0, 20));
            run_decode($urandom_range(0, 4) == 0, d, r, 1'b0);
        end
`ifdef RS_SEQ_WATCHDOG_EN
        wd_test();
        run_decode(1'b0, 4, 4, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
